// File: rtl/dds_voice_osc.sv
// DDS voice oscillator: 32-bit phase accumulator with saw/pulse/triangle/noise
// output, gate retrigger, hard sync and carry-out wrap pulse; two-stage pipeline.
module dds_voice_osc #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_stb,
    input  logic [31:0] adder,
    input  logic [1:0]  wave_sel,
    input  logic [11:0] pw,
    input  logic        gate,
    input  logic        sync_in,
    output logic [11:0] sample_out,
    output logic        sample_vld,
    output logic        wrap_out
);

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_PULSE = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_e;

    logic [31:0] phase_q, phase_d;
    logic        carry_q, carry_d;
    logic        restart_pend_q, restart_pend_d;
    logic        gate_prev_q, gate_prev_d;
    logic [1:0]  wave_sel_q, wave_sel_d;
    logic [11:0] pw_q, pw_d;
    logic        gate_q, gate_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        v1_q, v1_d;
    logic [11:0] sample_out_q, sample_out_d;
    logic        sample_vld_q, sample_vld_d;
    logic        wrap_out_q, wrap_out_d;

    logic        gate_rise;
    logic        restart;
    logic [32:0] sum;
    logic        lfsr_fb;
    logic [11:0] p;
    logic [10:0] tri_t;
    logic [11:0] wave;

    // A gate edge coinciding with a strobe restarts that very strobe, so it is
    // folded into the restart condition rather than parked in restart_pend.
    always_comb begin
        gate_rise      = gate & ~gate_prev_q;
        restart        = restart_pend_q | sync_in | gate_rise;
        sum            = {1'b0, phase_q} + {1'b0, adder};
        lfsr_fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        phase_d        = phase_q;
        carry_d        = carry_q;
        restart_pend_d = restart_pend_q;
        wave_sel_d     = wave_sel_q;
        pw_d           = pw_q;
        gate_d         = gate_q;
        lfsr_d         = lfsr_q;
        gate_prev_d    = gate;
        v1_d           = sample_stb;
        if (sample_stb) begin
            if (restart) begin
                phase_d = 32'h0;
                carry_d = 1'b0;
            end else begin
                {carry_d, phase_d} = sum;
            end
            restart_pend_d = 1'b0;
            wave_sel_d     = wave_sel;
            pw_d           = pw;
            gate_d         = gate;
            lfsr_d         = {lfsr_q[14:0], lfsr_fb};
        end else if (sync_in || gate_rise) begin
            restart_pend_d = 1'b1;
        end
    end

    always_comb begin
        p     = phase_q[31:20];
        tri_t = phase_q[31] ? ~phase_q[30:20] : phase_q[30:20];
        wave  = 12'h000;
        case (wave_e'(wave_sel_q))
            WAVE_SAW:   wave = p ^ 12'h800;
            WAVE_PULSE: wave = (p < pw_q) ? 12'h7FF : 12'h800;
            WAVE_TRI:   wave = {tri_t, 1'b0} ^ 12'h800;
            WAVE_NOISE: wave = lfsr_q[15:4];
            default:    wave = 12'h000;
        endcase
        sample_out_d = sample_out_q;
        if (v1_q) begin
            sample_out_d = gate_q ? wave : 12'h000;
        end
        sample_vld_d = v1_q;
        wrap_out_d   = v1_q & carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= 32'h0;
            carry_q        <= 1'b0;
            restart_pend_q <= 1'b0;
            gate_prev_q    <= 1'b0;
            wave_sel_q     <= 2'd0;
            pw_q           <= 12'h000;
            gate_q         <= 1'b0;
            lfsr_q         <= LFSR_SEED;
            v1_q           <= 1'b0;
            sample_out_q   <= 12'h000;
            sample_vld_q   <= 1'b0;
            wrap_out_q     <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            carry_q        <= carry_d;
            restart_pend_q <= restart_pend_d;
            gate_prev_q    <= gate_prev_d;
            wave_sel_q     <= wave_sel_d;
            pw_q           <= pw_d;
            gate_q         <= gate_d;
            lfsr_q         <= lfsr_d;
            v1_q           <= v1_d;
            sample_out_q   <= sample_out_d;
            sample_vld_q   <= sample_vld_d;
            wrap_out_q     <= wrap_out_d;
        end
    end

    assign sample_out = sample_out_q;
    assign sample_vld = sample_vld_q;
    assign wrap_out   = wrap_out_q;

endmodule
